// File: rtl/rv64_alu_pkg.sv
// +----------------------------------------------------------------------------+
// | rv64_alu_pkg                                                               |
// | ALU op codes and RV64I opcode/funct constants shared by the decode stage.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package rv64_alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_ADDW = 3'd1,
    ALU_SUB  = 3'd2,
    ALU_SUBW = 3'd3,
    ALU_SLL  = 3'd4,
    ALU_SLLW = 3'd5,
    ALU_SRA  = 3'd6,
    ALU_SRAW = 3'd7
  } alu_op_e;

  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SRA = 3'b101;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

`default_nettype wire

// File: rtl/rv64_alu_decode_if.sv
// +----------------------------------------------------------------------------+
// | rv64_alu_decode_if                                                         |
// | Instruction-in / ALU-bundle-out handshake bundle of the decode stage.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface rv64_alu_decode_if #(
  parameter int XLEN = 64
);
  import rv64_alu_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     inst;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  alu_op_e         alu_op;
  logic [4:0]      rd;
  logic            illegal;

  modport master (
    output in_valid, inst, rs1_val, rs2_val, out_ready,
    input  in_ready, out_valid, alu_a, alu_b, alu_op, rd, illegal
  );

  modport slave (
    input  in_valid, inst, rs1_val, rs2_val, out_ready,
    output in_ready, out_valid, alu_a, alu_b, alu_op, rd, illegal
  );

endinterface

`default_nettype wire

// File: rtl/rv64_alu_op_decode.sv
// +----------------------------------------------------------------------------+
// | rv64_alu_op_decode                                                         |
// | Combinational map of inst/rs1/rs2 to ALU operands, op code, illegal flag.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module rv64_alu_op_decode
  import rv64_alu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output alu_op_e         alu_op,
  output logic            illegal
);

  logic [6:0]      w_opc;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic            w_is_w;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_sh6_reg;
  logic [XLEN-1:0] w_sh5_reg;
  logic [XLEN-1:0] w_sh6_imm;
  logic [XLEN-1:0] w_sh5_imm;
  logic [XLEN-1:0] w_b;
  alu_op_e         w_op;
  logic            w_legal;
  logic            w_unused_fields;

  assign w_opc     = inst[6:0];
  assign w_f3      = inst[14:12];
  assign w_f7      = inst[31:25];
  assign w_is_w    = (w_opc == OPC_OP_32);
  assign w_imm_i   = {{(XLEN-12){inst[31]}}, inst[31:20]};
  assign w_sh6_reg = {{(XLEN-6){1'b0}}, rs2_val[5:0]};
  assign w_sh5_reg = {{(XLEN-5){1'b0}}, rs2_val[4:0]};
  assign w_sh6_imm = {{(XLEN-6){1'b0}}, inst[25:20]};
  assign w_sh5_imm = {{(XLEN-5){1'b0}}, inst[24:20]};

  // Register indices are consumed by the register file and the pipeline, not here.
  assign w_unused_fields = &{1'b0, inst[19:15], inst[11:7]};

  always_comb begin
    w_op    = ALU_ADD;
    w_b     = '0;
    w_legal = 1'b0;
    case (w_opc)
      OPC_OP, OPC_OP_32: begin
        if (w_f3 == F3_ADD && w_f7 == F7_BASE) begin
          w_op    = w_is_w ? ALU_ADDW : ALU_ADD;
          w_b     = rs2_val;
          w_legal = 1'b1;
        end else if (w_f3 == F3_ADD && w_f7 == F7_ALT) begin
          w_op    = w_is_w ? ALU_SUBW : ALU_SUB;
          w_b     = rs2_val;
          w_legal = 1'b1;
        end else if (w_f3 == F3_SLL && w_f7 == F7_BASE) begin
          w_op    = w_is_w ? ALU_SLLW : ALU_SLL;
          w_b     = w_is_w ? w_sh5_reg : w_sh6_reg;
          w_legal = 1'b1;
        end else if (w_f3 == F3_SRA && w_f7 == F7_ALT) begin
          w_op    = w_is_w ? ALU_SRAW : ALU_SRA;
          w_b     = w_is_w ? w_sh5_reg : w_sh6_reg;
          w_legal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        // 64-bit immediate shifts borrow inst[25] as shamt bit 5.
        if (w_f3 == F3_ADD) begin
          w_op    = ALU_ADD;
          w_b     = w_imm_i;
          w_legal = 1'b1;
        end else if (w_f3 == F3_SLL && inst[31:26] == 6'b000000) begin
          w_op    = ALU_SLL;
          w_b     = w_sh6_imm;
          w_legal = 1'b1;
        end else if (w_f3 == F3_SRA && inst[31:26] == 6'b010000) begin
          w_op    = ALU_SRA;
          w_b     = w_sh6_imm;
          w_legal = 1'b1;
        end
      end
      OPC_OP_IMM_32: begin
        if (w_f3 == F3_ADD) begin
          w_op    = ALU_ADDW;
          w_b     = w_imm_i;
          w_legal = 1'b1;
        end else if (w_f3 == F3_SLL && w_f7 == F7_BASE) begin
          w_op    = ALU_SLLW;
          w_b     = w_sh5_imm;
          w_legal = 1'b1;
        end else if (w_f3 == F3_SRA && w_f7 == F7_ALT) begin
          w_op    = ALU_SRAW;
          w_b     = w_sh5_imm;
          w_legal = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  assign alu_a   = w_legal ? rs1_val : '0;
  assign alu_b   = w_legal ? w_b : '0;
  assign alu_op  = w_legal ? w_op : ALU_ADD;
  assign illegal = ~w_legal;

endmodule

`default_nettype wire

// File: rtl/rv64_alu_decode.sv
// +----------------------------------------------------------------------------+
// | rv64_alu_decode                                                            |
// | Single-stage valid/ready decode register feeding the rv64_alu.             |
// | Optional: RV64_ALU_DECODE_STALL_CNT_EN adds a saturating stall counter.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module rv64_alu_decode
  import rv64_alu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic               clk,
  input  logic               rst,
  rv64_alu_decode_if.slave   bus
`ifdef RV64_ALU_DECODE_STALL_CNT_EN
  ,
  output logic [31:0]        stall_cnt
`endif
);

  logic [XLEN-1:0] w_dec_a;
  logic [XLEN-1:0] w_dec_b;
  alu_op_e         w_dec_op;
  logic            w_dec_illegal;
  logic            w_in_fire;
  logic            w_out_fire;

  logic            r_valid;
  logic [XLEN-1:0] r_alu_a;
  logic [XLEN-1:0] r_alu_b;
  alu_op_e         r_alu_op;
  logic [4:0]      r_rd;
  logic            r_illegal;

  rv64_alu_op_decode #(
    .XLEN (XLEN)
  ) u_op_decode (
    .inst    (bus.inst),
    .rs1_val (bus.rs1_val),
    .rs2_val (bus.rs2_val),
    .alu_a   (w_dec_a),
    .alu_b   (w_dec_b),
    .alu_op  (w_dec_op),
    .illegal (w_dec_illegal)
  );

  // Gating with rst keeps the upstream from seeing a transfer while the stage is held in reset.
  assign bus.in_ready = ~rst & (~r_valid | bus.out_ready);
  assign w_in_fire    = bus.in_valid & bus.in_ready;
  assign w_out_fire   = r_valid & bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_op  <= ALU_ADD;
      r_rd      <= '0;
      r_illegal <= 1'b0;
    end else if (w_in_fire) begin
      r_valid   <= 1'b1;
      r_alu_a   <= w_dec_a;
      r_alu_b   <= w_dec_b;
      r_alu_op  <= w_dec_op;
      r_rd      <= bus.inst[11:7];
      r_illegal <= w_dec_illegal;
    end else if (w_out_fire) begin
      r_valid   <= 1'b0;
    end
  end

  assign bus.out_valid = r_valid;
  assign bus.alu_a     = r_alu_a;
  assign bus.alu_b     = r_alu_b;
  assign bus.alu_op    = r_alu_op;
  assign bus.rd        = r_rd;
  assign bus.illegal   = r_illegal;

`ifdef RV64_ALU_DECODE_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (r_valid && !bus.out_ready && r_stall_cnt != 32'hFFFF_FFFF) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rv64_alu_decode.sv
// +----------------------------------------------------------------------------+
// | tb_rv64_alu_decode                                                         |
// | Directed vectors with a queue scoreboard for the rv64_alu_decode stage.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_rv64_alu_decode;

  typedef struct {
    logic [31:0] inst;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic [2:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [4:0]  rd;
    logic        ill;
  } vec_t;

  logic clk;
  logic rst;
`ifdef RV64_ALU_DECODE_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  rv64_alu_decode_if #(.XLEN(64)) bus ();

  rv64_alu_decode #(
    .XLEN (64)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus)
`ifdef RV64_ALU_DECODE_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            total = 0;
  int            bad = 0;
  int            run = 0;
  int            max_run = 0;
  vec_t          vecs[$];
  logic [136:0]  sb[$];

  function automatic logic [31:0] enc(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                      logic [2:0] f3, logic [4:0] rd, logic [6:0] opc);
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction

  function automatic void add(logic [31:0] inst, logic [63:0] rs1, logic [63:0] rs2,
                              logic [2:0] op, logic [63:0] a, logic [63:0] b,
                              logic [4:0] rd, logic ill);
    vec_t v;
    v.inst = inst; v.rs1 = rs1; v.rs2 = rs2;
    v.op = op; v.a = a; v.b = b; v.rd = rd; v.ill = ill;
    vecs.push_back(v);
  endfunction

  function automatic logic [136:0] exp_of(int i);
    return {vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].ill};
  endfunction

  function automatic logic [136:0] got_bundle();
    return {bus.alu_op, bus.alu_a, bus.alu_b, bus.rd, bus.illegal};
  endfunction

  task automatic check(string name, logic [136:0] got, logic [136:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Drive one vector and wait (bounded) for acceptance; expectation is queued at acceptance.
  task automatic send(int i);
    int n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.inst     = vecs[i].inst;
    bus.rs1_val  = vecs[i].rs1;
    bus.rs2_val  = vecs[i].rs2;
    #1;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!bus.in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout vec=%0d in_ready=%b required=1", i, bus.in_ready);
    end else begin
      sb.push_back(exp_of(i));
    end
  endtask

  // Monitor: pops one expectation per output transfer and tracks out_valid run length.
  always @(negedge clk) begin
    #2;
    if (rst) begin
      run = 0;
    end else if (bus.out_valid) begin
      run++;
      if (run > max_run) max_run = run;
      if (bus.out_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output got=%h required=none", got_bundle());
        end else begin
          check("bundle", got_bundle(), sb.pop_front());
        end
      end
    end else begin
      run = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    add(32'hFFF10093, 64'd5, 64'h99, 3'd0, 64'd5, 64'hFFFF_FFFF_FFFF_FFFF, 5'd1, 1'b0);
    add(32'h402081B3, 64'd10, 64'd3, 3'd2, 64'd10, 64'd3, 5'd3, 1'b0);
    add(32'h41F3529B, 64'h8000_0000_0000_0000, 64'h123, 3'd7, 64'h8000_0000_0000_0000, 64'd31, 5'd5, 1'b0);
    add(32'h009413BB, 64'h1234, 64'hFF, 3'd5, 64'h1234, 64'd31, 5'd7, 1'b0);
    add(32'h0203129B, 64'hAA, 64'hBB, 3'd0, 64'd0, 64'd0, 5'd5, 1'b1);
    add(enc(7'h00, 5'd12, 5'd11, 3'd0, 5'd10, 7'h33), 64'd1, 64'd2, 3'd0, 64'd1, 64'd2, 5'd10, 1'b0);
    add(enc(7'h00, 5'd3, 5'd2, 3'd1, 5'd4, 7'h33), 64'hFFFF_0000_0000_0001, 64'h7F, 3'd4,
        64'hFFFF_0000_0000_0001, 64'h3F, 5'd4, 1'b0);
    add(enc(7'h20, 5'd3, 5'd2, 3'd5, 5'd6, 7'h33), 64'hF0, 64'hC1, 3'd6, 64'hF0, 64'd1, 5'd6, 1'b0);
    add(enc(7'h00, 5'd3, 5'd2, 3'd0, 5'd8, 7'h3B), 64'h7FFF_FFFF, 64'd1, 3'd1, 64'h7FFF_FFFF, 64'd1, 5'd8, 1'b0);
    add(enc(7'h20, 5'd3, 5'd2, 3'd0, 5'd9, 7'h3B), 64'd7, 64'hDEAD_BEEF_0000_0001, 3'd3,
        64'd7, 64'hDEAD_BEEF_0000_0001, 5'd9, 1'b0);
    add(enc(7'h20, 5'd3, 5'd2, 3'd5, 5'd11, 7'h3B), 64'd1, 64'h3F, 3'd7, 64'd1, 64'h1F, 5'd11, 1'b0);
    add(enc(7'h21, 5'd8, 5'd2, 3'd5, 5'd12, 7'h13), 64'h55, 64'd0, 3'd6, 64'h55, 64'd40, 5'd12, 1'b0);
    add(enc(7'h01, 5'd31, 5'd2, 3'd1, 5'd13, 7'h13), 64'd3, 64'd0, 3'd4, 64'd3, 64'd63, 5'd13, 1'b0);
    add(enc(7'h3F, 5'd31, 5'd2, 3'd0, 5'd14, 7'h1B), 64'd9, 64'd0, 3'd1, 64'd9, 64'h7FF, 5'd14, 1'b0);
    add(enc(7'h00, 5'd3, 5'd2, 3'd7, 5'd15, 7'h33), 64'd1, 64'd1, 3'd0, 64'd0, 64'd0, 5'd15, 1'b1);
    add(enc(7'h02, 5'd0, 5'd2, 3'd1, 5'd16, 7'h13), 64'd1, 64'd1, 3'd0, 64'd0, 64'd0, 5'd16, 1'b1);
    add(enc(7'h20, 5'd3, 5'd2, 3'd1, 5'd17, 7'h33), 64'd1, 64'd1, 3'd0, 64'd0, 64'd0, 5'd17, 1'b1);
    add(enc(7'h09, 5'd5, 5'd6, 3'd3, 5'd18, 7'h37), 64'd1, 64'd1, 3'd0, 64'd0, 64'd0, 5'd18, 1'b1);
    add(enc(7'h01, 5'd3, 5'd2, 3'd0, 5'd19, 7'h3B), 64'd1, 64'd1, 3'd0, 64'd0, 64'd0, 5'd19, 1'b1);

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.inst      = 32'd0;
    bus.rs1_val   = 64'd0;
    bus.rs2_val   = 64'd0;
    bus.out_ready = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    check("reset_out_valid", 137'(bus.out_valid), 137'd0);
    check("reset_in_ready", 137'(bus.in_ready), 137'd0);
    check("reset_bundle", got_bundle(), 137'd0);
`ifdef RV64_ALU_DECODE_STALL_CNT_EN
    check("reset_stall_cnt", 137'(stall_cnt), 137'd0);
`endif
    rst = 1'b0;
    bus.out_ready = 1'b1;

    // Full-throughput stream of every vector.
    for (int i = 0; i < vecs.size(); i++) send(i);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #3;
    check("stream_drained", 137'(sb.size()), 137'd0);
    check("stream_no_bubble", 137'(max_run), 137'(vecs.size()));

    // Backpressure: SUB held for three cycles while another instruction waits.
    @(negedge clk);
    bus.out_ready = 1'b0;
    send(1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 0) begin
        bus.inst    = vecs[5].inst;
        bus.rs1_val = vecs[5].rs1;
        bus.rs2_val = vecs[5].rs2;
      end
      #1;
      check("hold_out_valid", 137'(bus.out_valid), 137'd1);
      check("hold_in_ready", 137'(bus.in_ready), 137'd0);
      check("hold_bundle", got_bundle(), exp_of(1));
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
`ifdef RV64_ALU_DECODE_STALL_CNT_EN
    check("stall_cnt", 137'(stall_cnt), 137'd3);
`endif
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #3;
    check("hold_drained", 137'(sb.size()), 137'd0);

    // Reset while a bundle is stalled at the output.
    @(negedge clk);
    bus.out_ready = 1'b0;
    send(2);
    @(negedge clk);
    #1;
    check("pre_reset_valid", 137'(bus.out_valid), 137'd1);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midreset_out_valid", 137'(bus.out_valid), 137'd0);
    check("midreset_in_ready", 137'(bus.in_ready), 137'd0);
    check("midreset_bundle", got_bundle(), 137'd0);
`ifdef RV64_ALU_DECODE_STALL_CNT_EN
    check("midreset_stall_cnt", 137'(stall_cnt), 137'd0);
`endif
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;

    send(3);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #3;
    check("final_drained", 137'(sb.size()), 137'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
